multi_port_rf_sequencer: RTL and testbench

MULTI_PORT_RF_SEQUENCER -- requirements
Module: multi_port_rf_sequencer

---
 rtl/multi_port_rf_sequencer_if.sv | 50 +++++
 rtl/multi_port_rf_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_multi_port_rf_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_port_rf_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | multi_port_rf_sequencer_if : request, register-file and response bundle |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
interface multi_port_rf_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_rd_mask;
  logic [4:0]  req_rd_addr0;
  logic [4:0]  req_rd_addr1;
  logic [4:0]  req_rd_addr2;
  logic [4:0]  req_rd_addr3;
  logic [1:0]  req_wr_mask;
  logic [4:0]  req_wr_addr0;
  logic [4:0]  req_wr_addr1;
  logic [63:0] req_wr_data0;
  logic [63:0] req_wr_data1;
  logic [3:0]  rf_ctrl;
  logic [63:0] rf_port1;
  logic [63:0] rf_port2;
  logic [63:0] rf_port3;
  logic [63:0] rf_port4;
  logic [63:0] rf_latch1;
  logic [63:0] rf_latch2;
  logic [63:0] rf_latch3;
  logic [63:0] rf_latch4;
  logic        rsp_valid;
  logic [63:0] rsp_data0;
  logic [63:0] rsp_data1;
  logic [63:0] rsp_data2;
  logic [63:0] rsp_data3;

  modport slave (
    input  req_valid, req_rd_mask, req_rd_addr0, req_rd_addr1, req_rd_addr2, req_rd_addr3,
    input  req_wr_mask, req_wr_addr0, req_wr_addr1, req_wr_data0, req_wr_data1,
    input  rf_latch1, rf_latch2, rf_latch3, rf_latch4,
    output req_ready, rf_ctrl, rf_port1, rf_port2, rf_port3, rf_port4,
    output rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3
  );

  modport master (
    output req_valid, req_rd_mask, req_rd_addr0, req_rd_addr1, req_rd_addr2, req_rd_addr3,
    output req_wr_mask, req_wr_addr0, req_wr_addr1, req_wr_data0, req_wr_data1,
    output rf_latch1, rf_latch2, rf_latch3, rf_latch4,
    input  req_ready, rf_ctrl, rf_port1, rf_port2, rf_port3, rf_port4,
    input  rsp_valid, rsp_data0, rsp_data1, rsp_data2, rsp_data3
  );
endinterface
`default_nettype wire

// File: rtl/multi_port_rf_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | multi_port_rf_sequencer : packs 4-read/2-write requests onto RF codes   |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module multi_port_rf_sequencer #(
  parameter logic [3:0] IDLE_CODE = 4'hF
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  multi_port_rf_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISS_A = 3'd1;
  localparam logic [2:0] S_ISS_B = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        live_q;
  logic [3:0]  rd_mask_q;
  logic [4:0]  rd_addr_q [4];
  logic [1:0]  wr_mask_q;
  logic [4:0]  wr_addr_q [2];
  logic [63:0] wr_data_q [2];
  logic [63:0] rsp_q [4];
  logic [63:0] rsp_d [4];

  logic        accept;
  logic [2:0]  r_cnt;
  logic [1:0]  w_cnt;
  logic        need_b;
  logic [4:0]  slot_addr [4];
  logic [1:0]  lane_slot [4];
  logic [4:0]  pend_addr;
  logic [63:0] pend_data;
  logic [3:0]  code;
  logic [63:0] port [4];
  logic [63:0] latch [4];

  assign accept   = bus.req_valid && bus.req_ready;
  assign latch[0] = bus.rf_latch1;
  assign latch[1] = bus.rf_latch2;
  assign latch[2] = bus.rf_latch3;
  assign latch[3] = bus.rf_latch4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_mask_q <= '0;
      wr_mask_q <= '0;
      for (int k = 0; k < 4; k++) rd_addr_q[k] <= '0;
      for (int j = 0; j < 2; j++) begin
        wr_addr_q[j] <= '0;
        wr_data_q[j] <= '0;
      end
    end else if (accept) begin
      rd_mask_q    <= bus.req_rd_mask;
      rd_addr_q[0] <= bus.req_rd_addr0;
      rd_addr_q[1] <= bus.req_rd_addr1;
      rd_addr_q[2] <= bus.req_rd_addr2;
      rd_addr_q[3] <= bus.req_rd_addr3;
      wr_mask_q    <= bus.req_wr_mask;
      wr_addr_q[0] <= bus.req_wr_addr0;
      wr_addr_q[1] <= bus.req_wr_addr1;
      wr_data_q[0] <= bus.req_wr_data0;
      wr_data_q[1] <= bus.req_wr_data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) rsp_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) rsp_q[k] <= rsp_d[k];
    end
  end

  // Compact requested lanes onto slots in ascending lane order.
  always_comb begin
    r_cnt = '0;
    for (int k = 0; k < 4; k++) slot_addr[k] = '0;
    for (int k = 0; k < 4; k++) begin
      lane_slot[k] = r_cnt[1:0];
      if (rd_mask_q[k]) begin
        slot_addr[r_cnt[1:0]] = rd_addr_q[k];
        r_cnt = r_cnt + 3'd1;
      end
    end
    w_cnt  = {1'b0, wr_mask_q[0]} + {1'b0, wr_mask_q[1]};
    need_b = ((w_cnt == 2'd2) && ((r_cnt == 3'd1) || (r_cnt == 3'd2))) ||
             ((r_cnt >= 3'd3) && (w_cnt != 2'd0));
    // Single-write slots take the first requested write; ISS_B after a split pair takes write 1.
    if ((state_q == S_ISS_B) && (w_cnt == 2'd2)) begin
      pend_addr = wr_addr_q[1];
      pend_data = wr_data_q[1];
    end else if (wr_mask_q[0]) begin
      pend_addr = wr_addr_q[0];
      pend_data = wr_data_q[0];
    end else begin
      pend_addr = wr_addr_q[1];
      pend_data = wr_data_q[1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && ((|bus.req_rd_mask) || (|bus.req_wr_mask))) state_d = S_ISS_A;
      S_ISS_A: begin
        if (need_b)              state_d = S_ISS_B;
        else if (r_cnt != 3'd0)  state_d = S_CAPT;
        else                     state_d = S_DONE;
      end
      S_ISS_B: state_d = (r_cnt != 3'd0) ? S_CAPT : S_DONE;
      S_CAPT:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    code = IDLE_CODE;
    for (int n = 0; n < 4; n++) port[n] = '0;
    for (int k = 0; k < 4; k++) rsp_d[k] = rsp_q[k];
    if (state_q == S_ISS_A) begin
      if ((w_cnt == 2'd0) || (r_cnt >= 3'd3)) code = {1'b0, r_cnt - 3'd1};
      else if (r_cnt == 3'd1)                 code = 4'd4;
      else if (r_cnt == 3'd2)                 code = 4'd5;
      else                                    code = (w_cnt == 2'd1) ? 4'd6 : 4'd7;
    end else if (state_q == S_ISS_B) begin
      code = ((r_cnt >= 3'd3) && (w_cnt == 2'd2)) ? 4'd7 : 4'd6;
    end
    if ((state_q == S_ISS_A) || (state_q == S_ISS_B)) begin
      case (code)
        4'd0, 4'd1, 4'd2, 4'd3: begin
          for (int n = 0; n < 4; n++)
            if (n <= int'(code)) port[n] = {59'd0, slot_addr[n]};
        end
        4'd4: begin
          port[0] = {59'd0, slot_addr[0]};
          port[1] = pend_data;
          port[2] = {59'd0, pend_addr};
        end
        4'd5: begin
          port[0] = {59'd0, slot_addr[0]};
          port[1] = {59'd0, slot_addr[1]};
          port[2] = pend_data;
          port[3] = {59'd0, pend_addr};
        end
        4'd6: begin
          port[0] = {59'd0, pend_addr};
          port[1] = pend_data;
        end
        4'd7: begin
          port[0] = {59'd0, wr_addr_q[0]};
          port[1] = wr_data_q[0];
          port[2] = {59'd0, wr_addr_q[1]};
          port[3] = wr_data_q[1];
        end
        default: ;
      endcase
    end
    if (state_q == S_CAPT) begin
      for (int k = 0; k < 4; k++) rsp_d[k] = rd_mask_q[k] ? latch[lane_slot[k]] : 64'd0;
    end
  end

  assign bus.req_ready = live_q && (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rf_ctrl   = code;
  assign bus.rf_port1  = port[0];
  assign bus.rf_port2  = port[1];
  assign bus.rf_port3  = port[2];
  assign bus.rf_port4  = port[3];
  assign bus.rsp_data0 = rsp_q[0];
  assign bus.rsp_data1 = rsp_q[1];
  assign bus.rsp_data2 = rsp_q[2];
  assign bus.rsp_data3 = rsp_q[3];
endmodule
`default_nettype wire

// File: tb/tb_multi_port_rf_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_multi_port_rf_sequencer : RF responder plus request-level reference  |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_multi_port_rf_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_port_rf_sequencer_if bus();
  multi_port_rf_sequencer #(.IDLE_CODE(4'hF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] seed(input int i);
    return 64'h1000_0000_0000_0000 + 64'(i) * 64'h0101_0101;
  endfunction

  // Register-file responder: samples the issued code mid-cycle and acts on the next edge.
  logic [63:0] rf  [32];
  logic [63:0] lat [4];
  logic [3:0]  s_ctrl = 4'hF;
  logic [63:0] s_p   [4];
  bit          rf_init;
  assign bus.rf_latch1 = lat[0];
  assign bus.rf_latch2 = lat[1];
  assign bus.rf_latch3 = lat[2];
  assign bus.rf_latch4 = lat[3];

  always @(negedge clk) begin
    s_ctrl = bus.rf_ctrl;
    s_p[0] = bus.rf_port1;
    s_p[1] = bus.rf_port2;
    s_p[2] = bus.rf_port3;
    s_p[3] = bus.rf_port4;
  end

  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= seed(i);
      for (int i = 0; i < 4; i++) lat[i] <= '0;
      rf_init <= 1'b1;
    end else if (rst_n) begin
      case (s_ctrl)
        4'd0, 4'd1, 4'd2, 4'd3:
          for (int n = 0; n < 4; n++) if (n <= int'(s_ctrl)) lat[n] <= rf[s_p[n][4:0]];
        4'd4: begin lat[0] <= rf[s_p[0][4:0]]; rf[s_p[2][4:0]] <= s_p[1]; end
        4'd5: begin lat[0] <= rf[s_p[0][4:0]]; lat[1] <= rf[s_p[1][4:0]]; rf[s_p[3][4:0]] <= s_p[2]; end
        4'd6: rf[s_p[0][4:0]] <= s_p[1];
        4'd7: begin rf[s_p[0][4:0]] <= s_p[1]; rf[s_p[2][4:0]] <= s_p[3]; end
        default: ;
      endcase
    end
  end

  // Request-level reference: reads see memory before the request's writes, write 1 last.
  logic [63:0] mem_m   [32];
  logic [63:0] exp_rsp [4];
  logic [63:0] iss_port [2][4];

  task automatic scramble();
    bus.req_valid    = 1'b0;
    bus.req_rd_mask  = 4'($urandom);
    bus.req_rd_addr0 = 5'($urandom);
    bus.req_rd_addr1 = 5'($urandom);
    bus.req_rd_addr2 = 5'($urandom);
    bus.req_rd_addr3 = 5'($urandom);
    bus.req_wr_mask  = 2'($urandom);
    bus.req_wr_addr0 = 5'($urandom);
    bus.req_wr_addr1 = 5'($urandom);
    bus.req_wr_data0 = {$urandom, $urandom};
    bus.req_wr_data1 = {$urandom, $urandom};
  endtask

  task automatic drive_and_accept(input logic [3:0] rm, input logic [4:0] a0, a1, a2, a3,
                                  input logic [1:0] wm, input logic [4:0] wa0, wa1,
                                  input logic [63:0] wd0, wd1);
    bit acc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;   bus.req_rd_mask = rm;
    bus.req_rd_addr0 = a0;  bus.req_rd_addr1 = a1;
    bus.req_rd_addr2 = a2;  bus.req_rd_addr3 = a3;
    bus.req_wr_mask = wm;   bus.req_wr_addr0 = wa0; bus.req_wr_addr1 = wa1;
    bus.req_wr_data0 = wd0; bus.req_wr_data1 = wd1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        acc = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("accept", 64'(acc), 64'd1);
    #1 scramble();
  endtask

  task automatic run_req(input string tag, input logic [3:0] rm, input logic [4:0] a0, a1, a2, a3,
                         input logic [1:0] wm, input logic [4:0] wa0, wa1,
                         input logic [63:0] wd0, wd1);
    logic [4:0] ra [4];
    logic [3:0] codes [4];
    int r, w, exp_lat, lat_n, ncode, exp_a, exp_b;
    bit nb, seen;
    ra = '{a0, a1, a2, a3};
    r  = $countones(rm);
    w  = $countones(wm);
    for (int k = 0; k < 4; k++)
      if (rm[k]) exp_rsp[k] = mem_m[ra[k]];
      else if (r != 0) exp_rsp[k] = '0;
    if (wm[0]) mem_m[wa0] = wd0;
    if (wm[1]) mem_m[wa1] = wd1;
    nb      = (w > 0) && (r > 0) && !(r <= 2 && w == 1);
    exp_lat = ((r > 0) ? 3 : 2) + (nb ? 1 : 0);
    if (w == 0)      exp_a = r - 1;
    else if (r == 0) exp_a = (w == 1) ? 6 : 7;
    else if (r == 1) exp_a = 4;
    else if (r == 2) exp_a = 5;
    else             exp_a = r - 1;
    exp_b = (r >= 3 && w == 2) ? 7 : 6;

    @(negedge clk);
    check({tag, "_ready_idle"}, 64'(bus.req_ready), 64'd1);
    drive_and_accept(rm, a0, a1, a2, a3, wm, wa0, wa1, wd0, wd1);
    ncode = 0; seen = 0; lat_n = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (bus.rf_ctrl != 4'hF && ncode < 2) begin
        codes[ncode] = bus.rf_ctrl;
        iss_port[ncode] = '{bus.rf_port1, bus.rf_port2, bus.rf_port3, bus.rf_port4};
        ncode++;
      end
      if (bus.rsp_valid) begin
        seen  = 1;
        lat_n = c;
      end
    end
    if (r + w == 0) begin
      check({tag, "_empty_rsp"}, 64'(seen), 64'd0);
      check({tag, "_empty_iss"}, 64'(ncode), 64'd0);
    end else begin
      check({tag, "_latency"}, 64'(lat_n), 64'(exp_lat));
      check({tag, "_ncodes"}, 64'(ncode), nb ? 64'd2 : 64'd1);
      if (ncode > 0) check({tag, "_code_a"}, 64'(codes[0]), 64'(exp_a));
      if (nb && ncode > 1) check({tag, "_code_b"}, 64'(codes[1]), 64'(exp_b));
      check({tag, "_rsp0"}, bus.rsp_data0, exp_rsp[0]);
      check({tag, "_rsp1"}, bus.rsp_data1, exp_rsp[1]);
      check({tag, "_rsp2"}, bus.rsp_data2, exp_rsp[2]);
      check({tag, "_rsp3"}, bus.rsp_data3, exp_rsp[3]);
    end
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 32; i++) mem_m[i] = seed(i);
    for (int k = 0; k < 4; k++) exp_rsp[k] = '0;
    scramble();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'(bus.rf_ctrl), 64'hF);
    check("rst_ports", bus.rf_port1 | bus.rf_port2 | bus.rf_port3 | bus.rf_port4, 64'd0);
    check("rst_rsp", bus.rsp_data0 | bus.rsp_data1 | bus.rsp_data2 | bus.rsp_data3, 64'd0);
    check("rst_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 64'(bus.req_ready), 64'd1);

    run_req("dblwr", 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd3, 5'd7, 64'hAA, 64'hBB);
    check("dblwr_p1", iss_port[0][0], 64'd3);
    check("dblwr_p2", iss_port[0][1], 64'hAA);
    check("dblwr_p3", iss_port[0][2], 64'd7);
    check("dblwr_p4", iss_port[0][3], 64'hBB);

    run_req("raw", 4'b1111, 5'd3, 5'd7, 5'd3, 5'd7, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
    check("raw_d0", bus.rsp_data0, 64'hAA);
    check("raw_d1", bus.rsp_data1, 64'hBB);
    check("raw_d3", bus.rsp_data3, 64'hBB);

    run_req("rbw", 4'b0011, 5'd3, 5'd7, 5'd0, 5'd0, 2'b11, 5'd3, 5'd7, 64'h11, 64'h22);
    check("rbw_d0", bus.rsp_data0, 64'hAA);
    check("rbw_d1", bus.rsp_data1, 64'hBB);
    check("rbw_c5_p3", iss_port[0][2], 64'h11);
    check("rbw_c5_p4", iss_port[0][3], 64'd3);
    check("rbw_c6_p1", iss_port[1][0], 64'd7);
    check("rbw_c6_p2", iss_port[1][1], 64'h22);

    run_req("sparse", 4'b1010, 5'd9, 5'd3, 5'd9, 5'd7, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
    check("sparse_d1", bus.rsp_data1, 64'h11);
    check("sparse_d3", bus.rsp_data3, 64'h22);
    check("sparse_d0", bus.rsp_data0 | bus.rsp_data2, 64'd0);
    check("sparse_ports", iss_port[0][2] | iss_port[0][3], 64'd0);
    check("sparse_p2", iss_port[0][1], 64'd7);

    run_req("samewr", 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd5, 5'd5, 64'h1, 64'h2);
    run_req("samerd", 4'b0001, 5'd5, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
    check("samerd_d0", bus.rsp_data0, 64'h2);

    // Abort during ISS_A: the pending write to 12 must never land.
    @(negedge clk);
    drive_and_accept(4'b1111, 5'd8, 5'd9, 5'd10, 5'd11, 2'b01, 5'd12, 5'd0, 64'hDEAD, 64'd0);
    @(negedge clk);
    check("abort_iss_a", 64'(bus.rf_ctrl), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ctrl", 64'(bus.rf_ctrl), 64'hF);
    check("abort_ports", bus.rf_port1 | bus.rf_port2 | bus.rf_port3 | bus.rf_port4, 64'd0);
    check("abort_ready", 64'(bus.req_ready), 64'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) exp_rsp[k] = '0;
    @(posedge clk); #1;
    check("abort_rel_ready", 64'(bus.req_ready), 64'd1);
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    run_req("abort_rd", 4'b0001, 5'd12, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0);

    for (int t = 0; t < 60; t++) begin
      run_req("rnd", 4'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              {$urandom, $urandom}, {$urandom, $urandom});
    end
    run_req("empty", 4'b0000, 5'd1, 5'd2, 5'd3, 5'd4, 2'b00, 5'd1, 5'd2, 64'd5, 64'd6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
